// File: rtl/ram_dma_if.sv
// Bus bundle for ram_dma: CPU-side request/status plus the RAM word port.
// RAM_DMA_FILL_EN adds the fill request bit.
interface ram_dma_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
`ifdef RAM_DMA_FILL_EN
    logic              fill;
`endif
    logic              busy;
    logic              done;
    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

`ifdef RAM_DMA_FILL_EN
    modport master (
        input  start, src, dst, len, fill, mem_dout,
        output busy, done, mem_ren, mem_wen, mem_addr, mem_din
    );
    modport slave (
        output start, src, dst, len, fill, mem_dout,
        input  busy, done, mem_ren, mem_wen, mem_addr, mem_din
    );
`else
    modport master (
        input  start, src, dst, len, mem_dout,
        output busy, done, mem_ren, mem_wen, mem_addr, mem_din
    );
    modport slave (
        output start, src, dst, len, mem_dout,
        input  busy, done, mem_ren, mem_wen, mem_addr, mem_din
    );
`endif
endinterface

// File: rtl/ram_dma.sv
// Word-by-word RAM block copy engine (read then write per word).
// Optional RAM_DMA_FILL_EN: fill=1 writes the src value as a pattern, skipping reads.
module ram_dma #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    ram_dma_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              fill_q, fill_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d  = bus.src;
                    dst_d  = bus.dst;
                    rem_d  = bus.len;
`ifdef RAM_DMA_FILL_EN
                    fill_d = bus.fill;
                    // The fill pattern rides in the data buffer so WR needs no special path.
                    if (bus.fill) buf_d = DATA_W'(bus.src);
`else
                    fill_d = 1'b0;
`endif
                    if (bus.len == '0)  state_d = DONE;
                    else if (fill_d)    state_d = WR;
                    else                state_d = RD;
                end
            end
            RD: begin
                buf_d   = bus.mem_dout;
                state_d = WR;
            end
            WR: begin
                src_d = src_q + ADDR_W'(1);
                dst_d = dst_q + ADDR_W'(1);
                rem_d = rem_q - ADDR_W'(1);
                if (rem_q == ADDR_W'(1)) state_d = DONE;
                else if (fill_q)         state_d = WR;
                else                     state_d = RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: everything decodes from the registered state.
    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.mem_ren  = 1'b0;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        case (state_q)
            RD: begin
                bus.busy     = 1'b1;
                bus.mem_ren  = 1'b1;
                bus.mem_addr = src_q;
            end
            WR: begin
                bus.busy     = 1'b1;
                bus.mem_wen  = 1'b1;
                bus.mem_addr = dst_q;
                bus.mem_din  = buf_q;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma with a behavioural RAM on the bus.
module tb_ram_dma;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_dma_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    ram_dma #(.ADDR_W(16), .DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] ram [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    assign bus.mem_dout = ram[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_wen)  ram[bus.mem_addr] <= bus.mem_din;
        else if (pre_we)  ram[pre_addr] <= pre_data;
    end

    int checks = 0;
    int errors = 0;
    int busy_n, done_n, both_n, done_at, cyc;
    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            input logic f);
        @(negedge clk);
        bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = l;
`ifdef RAM_DMA_FILL_EN
        bus.fill = f;
`else
        if (f) $display("fill requested without RAM_DMA_FILL_EN");
`endif
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic clear_mon();
        busy_n = 0; done_n = 0; both_n = 0; done_at = -1; cyc = 0;
        rd_log.delete();
        wr_log.delete();
    endtask

    task automatic sample_cycle();
        @(negedge clk);
        if (bus.busy) busy_n++;
        if (bus.done) begin
            done_n++;
            if (done_at < 0) done_at = cyc;
        end
        if (bus.mem_ren) rd_log.push_back(bus.mem_addr);
        if (bus.mem_wen) wr_log.push_back(bus.mem_addr);
        if (bus.mem_ren && bus.mem_wen) both_n++;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
`ifdef RAM_DMA_FILL_EN
        bus.fill = 1'b0;
`endif
        #12 rst_n = 1'b1;

        // Reset mid-RD, then a one-word copy
        preload(16'h0010, 16'h1234);
        do_start(16'h0010, 16'h0020, 16'h0001, 1'b0);
        @(negedge clk);
        check("rd_before_reset_ren", bus.mem_ren, 1);
        check("rd_before_reset_addr", bus.mem_addr, 16'h0010);
        rst_n = 1'b0;
        #1;
        check("reset_busy_done", {bus.busy, bus.done}, 0);
        check("reset_ren_wen", {bus.mem_ren, bus.mem_wen}, 0);
        check("reset_addr", bus.mem_addr, 0);
        check("reset_din", bus.mem_din, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(16'h0010, 16'h0020, 16'h0001, 1'b0);
        @(negedge clk);
        check("one_rd", {bus.busy, bus.mem_ren, bus.mem_wen, bus.mem_addr}, {3'b110, 16'h0010});
        @(negedge clk);
        check("one_wr", {bus.busy, bus.mem_ren, bus.mem_wen, bus.mem_addr}, {3'b101, 16'h0020});
        check("one_wr_din", bus.mem_din, 16'h1234);
        @(negedge clk);
        check("one_done", {bus.busy, bus.done}, 2'b01);
        @(negedge clk);
        check("one_done_low", bus.done, 0);
        check("one_ram", ram[16'h0020], 16'h1234);

        // Basic 4-word copy
        for (int i = 0; i < 4; i++) preload(16'h0100 + 16'(i), 16'hA001 + 16'(i));
        do_start(16'h0100, 16'h0200, 16'h0004, 1'b0);
        clear_mon();
        for (int i = 0; i < 12; i++) sample_cycle();
        check("copy_busy_cycles", busy_n, 8);
        check("copy_done_pulses", done_n, 1);
        check("copy_done_at", done_at, 8);
        check("copy_ren_wen_overlap", both_n, 0);
        for (int i = 0; i < 4; i++)
            check("copy_ram", ram[16'h0200 + 16'(i)], 16'hA001 + 16'(i));

        // Zero length
        do_start(16'h0700, 16'h0710, 16'h0000, 1'b0);
        clear_mon();
        for (int i = 0; i < 4; i++) sample_cycle();
        check("zero_done_at", done_at, 0);
        check("zero_done_pulses", done_n, 1);
        check("zero_busy", busy_n, 0);
        check("zero_reads", rd_log.size(), 0);
        check("zero_writes", wr_log.size(), 0);

        // Address wrap
        preload(16'hFFFE, 16'h1111);
        preload(16'hFFFF, 16'h2222);
        preload(16'h0000, 16'h3333);
        do_start(16'hFFFE, 16'h7FFF, 16'h0003, 1'b0);
        clear_mon();
        for (int i = 0; i < 9; i++) sample_cycle();
        check("wrap_reads", rd_log.size(), 3);
        check("wrap_writes", wr_log.size(), 3);
        if (rd_log.size() == 3 && wr_log.size() == 3) begin
            check("wrap_rd0", rd_log[0], 16'hFFFE);
            check("wrap_rd1", rd_log[1], 16'hFFFF);
            check("wrap_rd2", rd_log[2], 16'h0000);
            check("wrap_wr0", wr_log[0], 16'h7FFF);
            check("wrap_wr1", wr_log[1], 16'h8000);
            check("wrap_wr2", wr_log[2], 16'h8001);
        end
        check("wrap_ram0", ram[16'h7FFF], 16'h1111);
        check("wrap_ram1", ram[16'h8000], 16'h2222);
        check("wrap_ram2", ram[16'h8001], 16'h3333);

        // Start while busy and while in DONE
        preload(16'h0300, 16'hC001);
        preload(16'h0301, 16'hC002);
        preload(16'h0500, 16'hD001);
        preload(16'h0600, 16'h0000);
        preload(16'h0601, 16'h0000);
        do_start(16'h0300, 16'h0400, 16'h0002, 1'b0);
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            sample_cycle();
            if (i == 1 || i == 4) begin
                bus.start = 1'b1; bus.src = 16'h0500; bus.dst = 16'h0600; bus.len = 16'h0002;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("busy_start_done_pulses", done_n, 1);
        check("busy_start_busy_cycles", busy_n, 4);
        check("busy_start_ram0", ram[16'h0400], 16'hC001);
        check("busy_start_ram1", ram[16'h0401], 16'hC002);
        check("busy_start_untouched", ram[16'h0600], 16'h0000);

`ifdef RAM_DMA_FILL_EN
        // Fill
        do_start(16'hBEEF, 16'h0040, 16'h0005, 1'b1);
        clear_mon();
        for (int i = 0; i < 8; i++) sample_cycle();
        check("fill_busy_cycles", busy_n, 5);
        check("fill_reads", rd_log.size(), 0);
        check("fill_done_at", done_at, 5);
        for (int i = 0; i < 5; i++) check("fill_ram", ram[16'h0040 + 16'(i)], 16'hBEEF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
